// File: rtl/fifo_pkg.sv
// Shared sizing constants for the UART receive word FIFO.
package fifo_pkg;
  localparam int DATA_WIDTH  = 32;
  localparam int ADDR_WIDTH  = 11;
  localparam int COUNT_WIDTH = ADDR_WIDTH + 1;
  localparam int DEPTH       = 2 ** ADDR_WIDTH;
endpackage

// File: rtl/fifo_generator_if.sv
// Write/read handshake and status bundle between the FIFO and its producer/consumer.
interface fifo_generator_if;
  import fifo_pkg::*;

  logic [DATA_WIDTH-1:0]  din;
  logic                   wr_en;
  logic                   full;
  logic                   almost_empty;
  logic [COUNT_WIDTH-1:0] wr_data_count;
  logic                   rd_en;
  logic [DATA_WIDTH-1:0]  dout;
  logic                   empty;
  logic                   valid;
  logic                   overflow;
  logic                   underflow;

  modport slave (
    input  din, wr_en, rd_en,
    output full, almost_empty, wr_data_count, dout, empty, valid, overflow, underflow
  );

  modport master (
    output din, wr_en, rd_en,
    input  full, almost_empty, wr_data_count, dout, empty, valid, overflow, underflow
  );
endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port, no reset (block-RAM inferable).
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int DATA_W = DATA_WIDTH
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/fifo_generator.sv
// Single-clock 32-bit word FIFO with registered flags, occupancy count and error pulses.
module fifo_generator
  import fifo_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  fifo_generator_if.slave  bus
);
  logic [ADDR_WIDTH:0]    wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [COUNT_WIDTH-1:0] cnt_nxt;
  logic                   wr_acc, rd_acc;
  logic                   rd_seen;
  logic [DATA_WIDTH-1:0]  ram_q;

  // Acceptance uses the registered flags, i.e. the state at the start of the cycle.
  assign wr_acc     = bus.wr_en & ~bus.full;
  assign rd_acc     = bus.rd_en & ~bus.empty;
  assign wr_ptr_nxt = wr_ptr + {{ADDR_WIDTH{1'b0}}, wr_acc};
  assign rd_ptr_nxt = rd_ptr + {{ADDR_WIDTH{1'b0}}, rd_acc};
  assign cnt_nxt    = wr_ptr_nxt - rd_ptr_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      bus.empty         <= 1'b1;
      bus.almost_empty  <= 1'b1;
      bus.full          <= 1'b0;
      bus.wr_data_count <= '0;
      bus.valid         <= 1'b0;
      bus.overflow      <= 1'b0;
      bus.underflow     <= 1'b0;
      rd_seen           <= 1'b0;
    end else begin
      wr_ptr            <= wr_ptr_nxt;
      rd_ptr            <= rd_ptr_nxt;
      bus.empty         <= (wr_ptr_nxt == rd_ptr_nxt);
      bus.full          <= (wr_ptr_nxt[ADDR_WIDTH-1:0] == rd_ptr_nxt[ADDR_WIDTH-1:0]) &&
                           (wr_ptr_nxt[ADDR_WIDTH] != rd_ptr_nxt[ADDR_WIDTH]);
      bus.almost_empty  <= (cnt_nxt <= COUNT_WIDTH'(1));
      bus.wr_data_count <= cnt_nxt;
      bus.valid         <= rd_acc;
      bus.overflow      <= bus.wr_en & bus.full;
      bus.underflow     <= bus.rd_en & bus.empty;
      if (rd_acc) rd_seen <= 1'b1;
    end
  end

  // RAM output is not resettable; mask it to zero until the first accepted read after reset.
  assign bus.dout = rd_seen ? ram_q : '0;

  fifo_ram #(.ADDR_W(ADDR_WIDTH), .DATA_W(DATA_WIDTH)) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (bus.din),
    .re    (rd_acc),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (ram_q)
  );
endmodule

// File: tb/tb_fifo_generator.sv
// Directed plus randomized checks of fifo_generator against a queue-based reference model.
module tb_fifo_generator;
  localparam int DEPTH = 2048;

  logic clk;
  logic rst_n;
  fifo_generator_if bus();

  fifo_generator dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q[$];
  logic [31:0] e_dout;
  logic        e_valid, e_ovf, e_udf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".dout"},  bus.dout, e_dout);
    chk({tag, ".valid"}, 32'(bus.valid), 32'(e_valid));
    chk({tag, ".count"}, 32'(bus.wr_data_count), 32'(q.size()));
    chk({tag, ".empty"}, 32'(bus.empty), 32'(q.size() == 0));
    chk({tag, ".aempty"}, 32'(bus.almost_empty), 32'(q.size() <= 1));
    chk({tag, ".full"},  32'(bus.full), 32'(q.size() == DEPTH));
    chk({tag, ".ovf"},   32'(bus.overflow), 32'(e_ovf));
    chk({tag, ".udf"},   32'(bus.underflow), 32'(e_udf));
  endtask

  task automatic model_reset();
    q.delete();
    e_dout = '0; e_valid = 0; e_ovf = 0; e_udf = 0;
  endtask

  // One clock: drive request, apply model rules on pre-edge occupancy, check after the edge.
  task automatic cyc(input logic w, input logic [31:0] d, input logic r, input string tag);
    bit wa, ra;
    bus.wr_en = w; bus.din = d; bus.rd_en = r;
    wa = w && (q.size() < DEPTH);
    ra = r && (q.size() > 0);
    @(posedge clk);
    #1;
    e_valid = ra;
    e_ovf   = w && !wa;
    e_udf   = r && !ra;
    if (ra) e_dout = q.pop_front();
    if (wa) q.push_back(d);
    check_all(tag);
    bus.wr_en = 0; bus.rd_en = 0;
  endtask

  initial begin
    logic [31:0] last;
    bus.din = '0; bus.wr_en = 0; bus.rd_en = 0;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    // Three writes then three reads
    for (int i = 1; i <= 3; i++) cyc(1, 32'(i), 0, "wr3");
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 0, 1, "rd3");
      chk("rd3.order", bus.dout, 32'(i));
    end

    // Underflow: dout must hold
    last = e_dout;
    cyc(0, 0, 1, "udf");
    chk("udf.hold", bus.dout, last);

    // Fill to full, overflow attempt, simultaneous at full, drain
    for (int i = 0; i < DEPTH; i++) cyc(1, 32'h1000 + 32'(i), 0, "fill");
    cyc(1, 32'hDEADBEEF, 0, "ovf");
    cyc(1, 32'hDEADBEEF, 1, "full_rw");
    chk("full_rw.cnt", 32'(bus.wr_data_count), 32'd2047);
    while (q.size() > 0) begin
      cyc(0, 0, 1, "drain");
      chk("drain.nobeef", 32'(bus.dout == 32'hDEADBEEF), 32'd0);
    end

    // Simultaneous read and write at count 5
    for (int i = 0; i < 5; i++) cyc(1, $urandom, 0, "pre5");
    for (int i = 0; i < 4; i++) cyc(1, $urandom, 1, "rw5");
    chk("rw5.cnt", 32'(bus.wr_data_count), 32'd5);
    while (q.size() > 0) cyc(0, 0, 1, "drain5");

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 99) < 60), $urandom, 1'($urandom_range(0, 99) < 45), "rand");

    // Asynchronous reset with 10 words stored
    while (q.size() > 0) cyc(0, 0, 1, "drainr");
    for (int i = 0; i < 10; i++) cyc(1, $urandom, 0, "pre_rst");
    cyc(0, 0, 1, "pre_rst_rd");
    #2 rst_n = 0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    cyc(1, 32'hA5A5A5A5, 0, "post_wr");
    cyc(0, 0, 1, "post_rd");
    chk("post_rd.data", bus.dout, 32'hA5A5A5A5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
